// File: rtl/lsu_mem_bridge_if.sv
// Request/response handshake between the LSU and the memory bridge,
// plus the bridge's single-port SRAM bus.
interface lsu_mem_bridge_if #(
    parameter int DATA_W  = 64,
    parameter int SRAM_AW = 10
);
    logic               mem_req_val_i;
    logic               mem_req_rdy_o;
    logic               mem_req_is_write_i;
    logic [DATA_W-1:0]  mem_req_addr_i;
    logic [DATA_W-1:0]  mem_req_data_i;
    logic               mem_req_is_cas_i;
    logic               mem_rsp_val_o;
    logic               mem_rsp_rdy_i;
    logic [DATA_W-1:0]  mem_rsp_data_o;
    logic               sram_req_o;
    logic               sram_we_o;
    logic [SRAM_AW-1:0] sram_addr_o;
    logic [DATA_W-1:0]  sram_wdata_o;
    logic [DATA_W-1:0]  sram_rdata_i;

    // Environment side: LSU requester, response sink and SRAM macro.
    modport master (
        output mem_req_val_i, mem_req_is_write_i, mem_req_addr_i,
               mem_req_data_i, mem_req_is_cas_i, mem_rsp_rdy_i, sram_rdata_i,
        input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o,
               sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

    modport slave (
        input  mem_req_val_i, mem_req_is_write_i, mem_req_addr_i,
               mem_req_data_i, mem_req_is_cas_i, mem_rsp_rdy_i, sram_rdata_i,
        output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o,
               sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/lsu_mem_bridge.sv
// Memory-side bridge: serves LSU read/write/CAS requests one at a time
// against a 1-cycle-latency word SRAM; CAS is compare-against-zero.
module lsu_mem_bridge #(
    parameter int DATA_W  = 64,
    parameter int SRAM_AW = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    lsu_mem_bridge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        CAS_WR,
        RSP
    } state_t;

    state_t             state_reg;
    logic               is_write_reg;
    logic               is_cas_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [DATA_W-1:0]  old_reg;
    logic               rsp_val_reg;
    logic [DATA_W-1:0]  rsp_data_reg;
    logic               sram_req_reg;
    logic               sram_we_reg;
    logic [SRAM_AW-1:0] sram_addr_reg;
    logic [DATA_W-1:0]  sram_wdata_reg;

    // Byte offset and high address bits are dropped so addresses wrap.
    logic [SRAM_AW-1:0] req_index;
    logic               unused_addr_bits;
    assign req_index        = bus.mem_req_addr_i[SRAM_AW+2:3];
    assign unused_addr_bits = ^{bus.mem_req_addr_i[DATA_W-1:SRAM_AW+3],
                                bus.mem_req_addr_i[2:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            is_write_reg   <= 1'b0;
            is_cas_reg     <= 1'b0;
            data_reg       <= '0;
            old_reg        <= '0;
            rsp_val_reg    <= 1'b0;
            rsp_data_reg   <= '0;
            sram_req_reg   <= 1'b0;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.mem_req_val_i) begin
                        // SRAM controls are registered, so they are set up
                        // here to be live during ACCESS.
                        is_write_reg   <= bus.mem_req_is_write_i & ~bus.mem_req_is_cas_i;
                        is_cas_reg     <= bus.mem_req_is_cas_i;
                        data_reg       <= bus.mem_req_data_i;
                        sram_req_reg   <= 1'b1;
                        sram_we_reg    <= bus.mem_req_is_write_i & ~bus.mem_req_is_cas_i;
                        sram_addr_reg  <= req_index;
                        sram_wdata_reg <= bus.mem_req_data_i;
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_req_reg <= 1'b0;
                    sram_we_reg  <= 1'b0;
                    if (is_write_reg) begin
                        rsp_val_reg  <= 1'b1;
                        rsp_data_reg <= data_reg;
                        state_reg    <= RSP;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    old_reg <= bus.sram_rdata_i;
                    if (is_cas_reg && (bus.sram_rdata_i == '0)) begin
                        sram_req_reg   <= 1'b1;
                        sram_we_reg    <= 1'b1;
                        sram_wdata_reg <= data_reg;
                        state_reg      <= CAS_WR;
                    end else begin
                        rsp_val_reg  <= 1'b1;
                        rsp_data_reg <= bus.sram_rdata_i;
                        state_reg    <= RSP;
                    end
                end
                CAS_WR: begin
                    sram_req_reg <= 1'b0;
                    sram_we_reg  <= 1'b0;
                    rsp_val_reg  <= 1'b1;
                    rsp_data_reg <= old_reg;
                    state_reg    <= RSP;
                end
                RSP: begin
                    if (bus.mem_rsp_rdy_i) begin
                        rsp_val_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    sram_req_reg <= 1'b0;
                    sram_we_reg  <= 1'b0;
                    rsp_val_reg  <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_rdy_o  = (state_reg == IDLE);
    assign bus.mem_rsp_val_o  = rsp_val_reg;
    assign bus.mem_rsp_data_o = rsp_data_reg;
    assign bus.sram_req_o     = sram_req_reg;
    assign bus.sram_we_o      = sram_we_reg;
    assign bus.sram_addr_o    = sram_addr_reg;
    assign bus.sram_wdata_o   = sram_wdata_reg;
endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Memory-side stage directly downstream of the allocator LSU.
- Consumes the LSU's mem_req valid/ready request channel (read, write, CAS) and returns mem_rsp data over a valid/ready response channel.
- Drives a single-port, 1-cycle-read-latency word SRAM.
- Implements CAS atomically as an internal read-compare-write; one transaction is outstanding at a time.

Parameters:
- DATA_W, 64: data/address width; matches falafel_pkg DATA_W.
- SRAM_AW, 10: SRAM word-index width (2^SRAM_AW words of DATA_W bits).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- mem_req_val_i  in  1  request valid
- mem_req_rdy_o  out  1  request ready
- mem_req_is_write_i  in  1  1=write, 0=read (ignored when is_cas=1)
- mem_req_addr_i  in  DATA_W  byte address
- mem_req_data_i  in  DATA_W  write data / CAS swap value
- mem_req_is_cas_i  in  1  CAS request
- mem_rsp_val_o  out  1  response valid
- mem_rsp_rdy_i  in  1  response ready
- mem_rsp_data_o  out  DATA_W  response data
- sram_req_o  out  1  SRAM access enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  SRAM_AW  SRAM word index
- sram_wdata_o  out  DATA_W  SRAM write data
- sram_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read access

Behaviour:
- Reset:
  - rst_i asserted at any time forces state=IDLE asynchronously.
  - All outputs go low: mem_rsp_val_o=0, mem_rsp_data_o=0, sram_*=0. mem_req_rdy_o goes high once in IDLE.
  - Reset mid-transaction drops it with no response; SRAM contents are untouched.
  - A CAS write not yet issued is never issued.
- Address mapping: word index = mem_req_addr_i[SRAM_AW+2:3]. Bits [2:0] and bits above SRAM_AW+2 are ignored, so out-of-range addresses wrap.
- Request acceptance:
  - mem_req_rdy_o = (state==IDLE), combinational from state only.
  - A handshake (val&rdy) at cycle t latches op, index and data.
  - Request inputs are don't-care when no handshake occurs.
- FSM states: IDLE, ACCESS, CAPTURE, CAS_WR, RSP.
  - IDLE -> ACCESS on handshake.
  - ACCESS: sram_req_o=1 (registered); sram_we_o=1 only for a plain write, with sram_wdata_o=latched data.
    - Write: -> RSP, response data = latched write data.
    - Read or CAS: -> CAPTURE.
  - CAPTURE: sram_rdata_i is latched as old value.
    - Read: -> RSP, data=old.
    - CAS with old==0: -> CAS_WR.
    - CAS with old!=0: -> RSP, data=old, no write.
  - CAS_WR: sram_req_o=1, sram_we_o=1, wdata=latched swap value, same index. -> RSP, data=old (0).
  - RSP: mem_rsp_val_o=1, data held stable until mem_rsp_rdy_i=1. Then -> IDLE; val drops the next cycle.
- CAS semantics: compare-against-zero (lock/free-slot acquire).
  - Success ⇔ returned data==0.
  - No other request can reach the SRAM between the CAS read and the CAS write.
- Latency, handshake at t, rsp_rdy held high:
  - write: rsp_val at t+2
  - read: rsp_val at t+3
  - failed CAS: rsp_val at t+3
  - successful CAS: rsp_val at t+4
  - Earliest next accept is the cycle after the response handshake.
- Back-pressure: rsp_rdy low holds state RSP indefinitely. No SRAM activity occurs and mem_req_rdy_o stays 0.
- sram_req_o and sram_we_o are 0 in IDLE, CAPTURE and RSP.

Test Plan:
- Write addr 0x40, data 0xDEAD_BEEF, then read 0x40 -> write rsp at t+2 with data 0xDEAD_BEEF; read rsp at t+3 with data 0xDEAD_BEEF; sram_addr_o=8 both times.
- CAS addr 0x80, data 0x1, word pre-zeroed -> rsp data 0 at t+4; a following read of 0x80 returns 0x1; exactly one sram_we_o pulse.
- Second CAS to 0x80 with data 0x2 -> rsp data 0x1 at t+3; no sram_we_o pulse; a read still returns 0x1.
- Read rsp with mem_rsp_rdy_i low for 5 cycles -> val and data stable for all 5; mem_req_rdy_o=0 throughout; IDLE the cycle after the rdy handshake.
- rst_i pulsed during a successful CAS in CAPTURE -> no sram_we_o, no response; word still 0; mem_req_rdy_o=1 after reset release.
- Address 0x4000_0047 with SRAM_AW=10 -> sram_addr_o=8, low bits ignored and wrap verified.
